// File: rtl/alu_result_stage_pkg.sv
// Shared definitions for the ALU result stage: operation tags, buffer states
// and flag bit positions.
package alu_result_stage_pkg;

   localparam logic [2:0] SEL_ADD  = 3'd0;
   localparam logic [2:0] SEL_SUB  = 3'd1;
   localparam logic [2:0] SEL_AND  = 3'd2;
   localparam logic [2:0] SEL_OR   = 3'd3;
   localparam logic [2:0] SEL_XOR  = 3'd4;
   localparam logic [2:0] SEL_SHL  = 3'd5;
   localparam logic [2:0] SEL_SHR  = 3'd6;
   localparam logic [2:0] SEL_PASS = 3'd7;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } stage_state_e;

   localparam int FLAG_W = 4;
   localparam int FLAG_Z = 0;
   localparam int FLAG_N = 1;
   localparam int FLAG_P = 2;
   localparam int FLAG_C = 3;

   // Only the arithmetic tags produce a meaningful carry/borrow.
   function automatic logic sel_has_carry(input logic [2:0] sel);
      return (sel == SEL_ADD) || (sel == SEL_SUB);
   endfunction

endpackage

// File: rtl/alu_result_stage_if.sv
// Upstream/downstream handshake bundle of the ALU result stage.
interface alu_result_stage_if #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 16
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic [2:0]        in_sel;
   logic              in_carry;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [2:0]        out_sel;
   logic [3:0]        out_flags;
   logic [CNT_W-1:0]  res_count;

   modport slave (
      input  in_valid, in_data, in_sel, in_carry, out_ready,
      output in_ready, out_valid, out_data, out_sel, out_flags, res_count
   );

   modport master (
      output in_valid, in_data, in_sel, in_carry, out_ready,
      input  in_ready, out_valid, out_data, out_sel, out_flags, res_count
   );
endinterface

// File: rtl/alu_flag_gen.sv
// Combinational flag generator: {carry, parity, negative, zero} for one result word.
module alu_flag_gen
   import alu_result_stage_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic [DATA_W-1:0] data,
   input  logic [2:0]        sel,
   input  logic              carry,
   output logic [FLAG_W-1:0] flags
);

   always_comb begin
      flags         = '0;
      flags[FLAG_Z] = (data == '0);
      flags[FLAG_N] = data[DATA_W-1];
      flags[FLAG_P] = ^data;
      flags[FLAG_C] = sel_has_carry(sel) & carry;
   end

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: 2-entry skid buffer capturing result, tag and flags, with
// a registered in_ready and a delivered-result counter.
//   state    | meaning
//   EMPTY    | nothing buffered, out_valid low
//   ONE      | main entry holds the presented result
//   TWO      | main and skid full, in_ready low
module alu_result_stage
   import alu_result_stage_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   alu_result_stage_if.slave bus
);

   stage_state_e      state_q, state_d;
   logic              in_ready_q;
   logic [DATA_W-1:0] main_data_q, skid_data_q;
   logic [2:0]        main_sel_q, skid_sel_q;
   logic [FLAG_W-1:0] main_flags_q, skid_flags_q, in_flags;
   logic [CNT_W-1:0]  cnt_q;
   logic              in_fire, out_fire;
   logic              load_main_in, load_skid, load_main_skid;

   alu_flag_gen #(.DATA_W(DATA_W)) u_flag_gen (
      .data  (bus.in_data),
      .sel   (bus.in_sel),
      .carry (bus.in_carry),
      .flags (in_flags)
   );

   always_comb begin
      state_d        = state_q;
      load_main_in   = 1'b0;
      load_skid      = 1'b0;
      load_main_skid = 1'b0;
      in_fire        = bus.in_valid & in_ready_q;
      out_fire       = (state_q != ST_EMPTY) & bus.out_ready;
      case (state_q)
         ST_EMPTY: begin
            if (in_fire) begin
               load_main_in = 1'b1;
               state_d      = ST_ONE;
            end
         end
         ST_ONE: begin
            case ({in_fire, out_fire})
               2'b11: load_main_in = 1'b1;
               2'b10: begin
                  load_skid = 1'b1;
                  state_d   = ST_TWO;
               end
               2'b01: state_d = ST_EMPTY;
               default: state_d = ST_ONE;
            endcase
         end
         ST_TWO: begin
            if (out_fire) begin
               load_main_skid = 1'b1;
               state_d        = ST_ONE;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_EMPTY;
         in_ready_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         // Registered from next state so out_ready never reaches in_ready combinationally.
         in_ready_q <= (state_d != ST_TWO);
         if (out_fire) cnt_q <= cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_data_q  <= '0;
         main_sel_q   <= '0;
         main_flags_q <= '0;
         skid_data_q  <= '0;
         skid_sel_q   <= '0;
         skid_flags_q <= '0;
      end else begin
         if (load_main_in) begin
            main_data_q  <= bus.in_data;
            main_sel_q   <= bus.in_sel;
            main_flags_q <= in_flags;
         end else if (load_main_skid) begin
            main_data_q  <= skid_data_q;
            main_sel_q   <= skid_sel_q;
            main_flags_q <= skid_flags_q;
         end
         if (load_skid) begin
            skid_data_q  <= bus.in_data;
            skid_sel_q   <= bus.in_sel;
            skid_flags_q <= in_flags;
         end
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = (state_q != ST_EMPTY);
   assign bus.out_data  = main_data_q;
   assign bus.out_sel   = main_sel_q;
   assign bus.out_flags = main_flags_q;
   assign bus.res_count = cnt_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: random and directed traffic against a queue-based
// reference of the buffered results.
module tb_alu_result_stage;

   typedef struct {
      logic [7:0] data;
      logic [2:0] sel;
      logic [3:0] flags;
   } entry_t;

   logic clk;
   logic rst_n;
   int   n_checks = 0;
   int   n_errors = 0;

   entry_t      model_q[$];
   logic [15:0] model_cnt;

   alu_result_stage_if #(.DATA_W(8), .CNT_W(16)) bus ();

   alu_result_stage #(.DATA_W(8), .CNT_W(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [3:0] ref_flags(input logic [7:0] d, input logic [2:0] s, input logic c);
      logic carry_f, par_f, neg_f, zero_f;
      zero_f  = (d == 8'd0);
      neg_f   = (d >= 8'd128);
      par_f   = ($countones(d) % 2) == 1;
      carry_f = (s == 3'd0 || s == 3'd1) ? c : 1'b0;
      return {carry_f, par_f, neg_f, zero_f};
   endfunction

   // Called at a falling edge: drive inputs, check outputs against the model,
   // advance the model by whatever transfers the coming rising edge performs.
   task automatic cycle(input logic iv, input logic [7:0] d, input logic [2:0] s,
                        input logic c, input logic ordy);
      entry_t e;
      bit in_f, out_f;
      bus.in_valid  = iv;
      bus.in_data   = d;
      bus.in_sel    = s;
      bus.in_carry  = c;
      bus.out_ready = ordy;
      check("in_ready", 32'(bus.in_ready), 32'(model_q.size() < 2));
      check("out_valid", 32'(bus.out_valid), 32'(model_q.size() != 0));
      if (model_q.size() != 0) begin
         check("out_data", 32'(bus.out_data), 32'(model_q[0].data));
         check("out_sel", 32'(bus.out_sel), 32'(model_q[0].sel));
         check("out_flags", 32'(bus.out_flags), 32'(model_q[0].flags));
      end
      check("res_count", 32'(bus.res_count), 32'(model_cnt));
      in_f  = iv && (model_q.size() < 2);
      out_f = ordy && (model_q.size() != 0);
      if (out_f) begin
         void'(model_q.pop_front());
         model_cnt = model_cnt + 16'd1;
      end
      if (in_f) begin
         e.data  = d;
         e.sel   = s;
         e.flags = ref_flags(d, s, c);
         model_q.push_back(e);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle(input logic ordy);
      cycle(1'b0, 8'($urandom), 3'($urandom), 1'($urandom), ordy);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      model_q.delete();
      model_cnt = 16'd0;
      @(negedge clk);
      rst_n = 1'b1;
      check("rdy_before_edge", 32'(bus.in_ready), 32'd0);
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_sel    = '0;
      bus.in_carry  = 1'b0;
      bus.out_ready = 1'b0;
      model_cnt     = 16'd0;
      rst_n         = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_in_ready", 32'(bus.in_ready), 32'd0);
      check("rst_out_data", 32'(bus.out_data), 32'd0);
      check("rst_out_sel", 32'(bus.out_sel), 32'd0);
      check("rst_out_flags", 32'(bus.out_flags), 32'd0);
      check("rst_res_count", 32'(bus.res_count), 32'd0);
      rst_n = 1'b1;
      check("rdy_before_edge", 32'(bus.in_ready), 32'd0);
      @(posedge clk);
      @(negedge clk);

      // single transfer, zero data with add carry
      cycle(1'b1, 8'h00, 3'd0, 1'b1, 1'b1);
      cycle(1'b0, 8'h55, 3'd2, 1'b0, 1'b1);
      check("single_count", 32'(bus.res_count), 32'd1);

      // backpressure: fill both entries, hold, then drain
      cycle(1'b1, 8'h80, 3'd2, 1'b1, 1'b0);
      cycle(1'b1, 8'h7F, 3'd3, 1'b1, 1'b0);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      cycle(1'b1, 8'hAA, 3'd4, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
      check("bp_hold_data", 32'(bus.out_data), 32'h80);
      repeat (3) idle(1'b1);

      // carry masking on a non-arithmetic tag
      cycle(1'b1, 8'h03, 3'd5, 1'b1, 1'b1);
      check("mask_carry", 32'(bus.out_flags[3]), 32'd0);
      check("mask_parity", 32'(bus.out_flags[2]), 32'd0);
      idle(1'b1);

      // streaming 0..99
      do_reset();
      for (int i = 0; i < 100; i++) cycle(1'b1, 8'(i), 3'($urandom), 1'($urandom), 1'b1);
      idle(1'b1);
      check("stream_count", 32'(bus.res_count), 32'd100);

      // random traffic with varying backpressure
      for (int i = 0; i < 600; i++) begin
         cycle(1'($urandom_range(0, 3) != 0), 8'($urandom), 3'($urandom), 1'($urandom),
               (i < 300) ? 1'($urandom_range(0, 3) == 0) : 1'($urandom_range(0, 1)));
      end
      repeat (3) idle(1'b1);

      // reset pulse between edges while both entries are full
      cycle(1'b1, 8'h11, 3'd0, 1'b1, 1'b0);
      cycle(1'b1, 8'h22, 3'd1, 1'b0, 1'b0);
      check("two_in_ready", 32'(bus.in_ready), 32'd0);
      #2 rst_n = 1'b0;
      model_q.delete();
      model_cnt = 16'd0;
      #1;
      check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
      check("midrst_in_ready", 32'(bus.in_ready), 32'd0);
      check("midrst_out_data", 32'(bus.out_data), 32'd0);
      check("midrst_count", 32'(bus.res_count), 32'd0);
      #1 rst_n = 1'b1;
      check("midrst_rdy_pre", 32'(bus.in_ready), 32'd0);
      @(posedge clk);
      @(negedge clk);
      check("midrst_rdy_post", 32'(bus.in_ready), 32'd1);
      repeat (3) idle(1'b1);

      // counter wrap: 65535 transfers, then one more
      do_reset();
      for (int i = 0; i < 65536; i++) cycle(1'b1, 8'(i), 3'(i), 1'(i), 1'b1);
      check("wrap_max", 32'(bus.res_count), 32'hFFFF);
      cycle(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
      check("wrap_zero", 32'(bus.res_count), 32'd0);
      idle(1'b1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
